// File: rtl/throw_pkg.sv
// Shared types and fixed-point formats for the projectile throw controllers.
package throw_pkg;

  // Position is signed Q13.4, velocity is signed Q7.4.
  localparam int POS_W  = 18;
  localparam int VEL_W  = 12;
  localparam int FRAC_W = 4;
  localparam int PIX_W  = 12;

  // Default per-frame vy decrement in Q.4 (0.25 px/frame^2).
  localparam int DEF_GRAVITY = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLIGHT = 2'd1,
    ST_DONE   = 2'd2
  } throw_state_e;

  typedef logic signed [POS_W-1:0]        pos_t;
  typedef logic signed [VEL_W-1:0]        vel_t;
  // Whole-pixel part of a position, still signed.
  typedef logic signed [POS_W-FRAC_W-1:0] pix_int_t;

  // Convert a whole-pixel coordinate to the Q13.4 position format.
  function automatic pos_t px_to_pos(input int px);
    return pos_t'(px * (1 << FRAC_W));
  endfunction

endpackage

// File: rtl/vga_pkg.sv
// VGA timing constants shared by the video-facing blocks.
package vga_pkg;

  localparam int HOR_PIXELS = 640;
  localparam int VER_PIXELS = 480;

endpackage

// File: rtl/edge_det.sv
// Registered rising-edge detector: one-clk pulse after a 0->1 transition.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic pulse
);

  logic prev_q, prev_d;
  logic pulse_q, pulse_d;

  // Compare current input against the previous sample.
  always_comb begin
    prev_d  = sig_in;
    pulse_d = sig_in & ~prev_q;
  end

  // Previous-sample and pulse registers; prev clears so a high input after reset yields one pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/projectile_ctl_cat.sv
// Projectile flight controller: launches on fire, steps ballistic physics once
// per video frame, and reports whether the shot landed on the target.
module projectile_ctl_cat
  import throw_pkg::*, vga_pkg::*;
#(
  parameter int START_X = 100,
  parameter int START_Y = 50,
  parameter int GRAVITY = DEF_GRAVITY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vsync,
  input  logic             fire,
  input  logic [6:0]       power_x,
  input  logic [6:0]       power_y,
  input  logic [4:0]       wind,
  input  logic [PIX_W-1:0] target_x_lo,
  input  logic [PIX_W-1:0] target_x_hi,
  input  logic [PIX_W-1:0] target_top,
  output logic [PIX_W-1:0] x_pos,
  output logic [PIX_W-1:0] y_pos,
  output logic             active,
  output logic             done,
  output logic             hit
);

  localparam pos_t     START_POS_X = px_to_pos(START_X);
  localparam pos_t     START_POS_Y = px_to_pos(START_Y);
  localparam vel_t     GRAV_V      = vel_t'(GRAVITY);
  // Allow the projectile a little past the right edge before giving up.
  localparam pix_int_t OOB_LIMIT   = pix_int_t'(HOR_PIXELS + 30);

  throw_state_e state_q, state_d;
  pos_t         pos_x_q, pos_x_d;
  pos_t         pos_y_q, pos_y_d;
  vel_t         vel_x_q, vel_x_d;
  vel_t         vel_y_q, vel_y_d;
  logic         check_q, check_d;
  logic         active_q, active_d;
  logic         done_q, done_d;
  logic         hit_q, hit_d;
  logic         tick;

  edge_det u_vsync_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_in (vsync),
    .pulse  (tick)
  );

  // Extended operands for the physics step and the end-of-flight tests.
  pos_t     vx_ext, vy_ext;
  vel_t     wind_ext, vx_load, vy_load;
  pix_int_t x_int, y_int;
  logic     x_in_range, y_below_top, y_ground, x_out;

  // Operand extension and end-condition tests on the current position.
  always_comb begin
    vx_ext      = {{(POS_W-VEL_W){vel_x_q[VEL_W-1]}}, vel_x_q};
    vy_ext      = {{(POS_W-VEL_W){vel_y_q[VEL_W-1]}}, vel_y_q};
    wind_ext    = {{(VEL_W-5){wind[4]}}, wind};
    vx_load     = {{(VEL_W-7){1'b0}}, power_x};
    vy_load     = {{(VEL_W-7){1'b0}}, power_y};
    x_int       = pos_x_q[POS_W-1:FRAC_W];
    y_int       = pos_y_q[POS_W-1:FRAC_W];
    // Signed whole-pixel compares so a negative position never wraps into range.
    x_in_range  = (x_int >= pix_int_t'({2'b00, target_x_lo})) &&
                  (x_int <= pix_int_t'({2'b00, target_x_hi}));
    y_below_top = (y_int <= pix_int_t'({2'b00, target_top}));
    y_ground    = pos_y_q[POS_W-1] || (pos_y_q == '0);
    x_out       = pos_x_q[POS_W-1] || (x_int >= OOB_LIMIT);
  end

  // Next-state, physics update and registered-output decode.
  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    vel_x_d = vel_x_q;
    vel_y_d = vel_y_q;
    check_d = 1'b0;
    hit_d   = hit_q;

    unique case (state_q)
      ST_IDLE: begin
        if (fire) begin
          pos_x_d = START_POS_X;
          pos_y_d = START_POS_Y;
          vel_x_d = vx_load;
          vel_y_d = vy_load;
          hit_d   = 1'b0;
          state_d = ST_FLIGHT;
        end
      end
      ST_FLIGHT: begin
        if (check_q) begin
          // End tests run one clk after the step, on the updated position.
          if (x_in_range && y_below_top) begin
            hit_d   = 1'b1;
            state_d = ST_DONE;
          end else if (y_ground) begin
            pos_y_d = '0;
            hit_d   = 1'b0;
            state_d = ST_DONE;
          end else if (x_out) begin
            hit_d   = 1'b0;
            state_d = ST_DONE;
          end
        end else if (tick) begin
          pos_x_d = pos_x_q + vx_ext;
          pos_y_d = pos_y_q + vy_ext;
          vel_x_d = vel_x_q + wind_ext;
          vel_y_d = vel_y_q - GRAV_V;
          check_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    active_d = (state_d == ST_FLIGHT);
    done_d   = (state_d == ST_DONE);
  end

  // State, physics and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pos_x_q  <= START_POS_X;
      pos_y_q  <= START_POS_Y;
      vel_x_q  <= '0;
      vel_y_q  <= '0;
      check_q  <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      vel_x_q  <= vel_x_d;
      vel_y_q  <= vel_y_d;
      check_q  <= check_d;
      active_q <= active_d;
      done_q   <= done_d;
      hit_q    <= hit_d;
    end
  end

  assign x_pos  = pos_x_q[FRAC_W+PIX_W-1:FRAC_W];
  assign y_pos  = pos_y_q[FRAC_W+PIX_W-1:FRAC_W];
  assign active = active_q;
  assign done   = done_q;
  assign hit    = hit_q;

endmodule

// File: tb/tb_projectile_ctl_cat.sv
// Randomized scoreboard bench for projectile_ctl_cat.
module tb_projectile_ctl_cat;

  localparam int START_X = 100;
  localparam int START_Y = 50;
  localparam int GRAV    = 4;
  localparam int OOB_X   = 640 + 30;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync;
  logic        fire;
  logic [6:0]  power_x;
  logic [6:0]  power_y;
  logic [4:0]  wind;
  logic [11:0] target_x_lo;
  logic [11:0] target_x_hi;
  logic [11:0] target_top;
  logic [11:0] x_pos;
  logic [11:0] y_pos;
  logic        active;
  logic        done;
  logic        hit;

  always #5 clk = ~clk;

  projectile_ctl_cat #(
    .START_X (START_X),
    .START_Y (START_Y),
    .GRAVITY (GRAV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vsync       (vsync),
    .fire        (fire),
    .power_x     (power_x),
    .power_y     (power_y),
    .wind        (wind),
    .target_x_lo (target_x_lo),
    .target_x_hi (target_x_hi),
    .target_top  (target_top),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .active      (active),
    .done        (done),
    .hit         (hit)
  );

  typedef struct {
    int x;
    int y;
    int hit;
  } result_t;

  int      n_checks = 0;
  int      n_pass   = 0;
  int      done_cnt = 0;
  result_t exp_q[$];
  int      traj_x[$];
  int      traj_y[$];
  result_t mon_r;
  logic    done_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference flight: plain integer ballistics in 1/16 px units, one step per frame.
  task automatic predict(input int px, input int py, input int w, input int lo,
                         input int hi, input int top, output result_t r, output int ticks);
    int x, y, vx, vy, xi, yi;
    x = START_X * 16;
    y = START_Y * 16;
    vx = px;
    vy = py;
    r.hit = 0;
    ticks = 0;
    traj_x.delete();
    traj_y.delete();
    for (int k = 1; k <= 400; k++) begin
      x = x + vx;
      y = y + vy;
      vx = vx + w;
      vy = vy - GRAV;
      xi = x >>> 4;
      yi = y >>> 4;
      ticks = k;
      if (xi >= lo && xi <= hi && yi <= top) begin
        r.hit = 1;
        break;
      end
      if (y <= 0) begin
        y = 0;
        break;
      end
      if (x < 0 || xi >= OOB_X) break;
      traj_x.push_back(xi & 12'hFFF);
      traj_y.push_back(yi & 12'hFFF);
    end
    r.x = (x >>> 4) & 12'hFFF;
    r.y = (y >>> 4) & 12'hFFF;
  endtask

  // One video frame: vsync high 4 clks, low 4 clks.
  task automatic frame();
    vsync = 1'b1;
    repeat (4) @(posedge clk);
    #1 vsync = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic run_flight(input int px, input int py, input int w, input int lo,
                            input int hi, input int top, input int coincide,
                            input int mid_fire);
    result_t r;
    int n, base;
    power_x = 7'(px);
    power_y = 7'(py);
    wind = 5'(w);
    target_x_lo = 12'(lo);
    target_x_hi = 12'(hi);
    target_top = 12'(top);
    predict(px, py, w, lo, hi, top, r, n);
    exp_q.push_back(r);
    base = done_cnt;
    if (coincide != 0) begin
      // Launch lands on the same clk as a frame tick: that tick must not step.
      vsync = 1'b1;
      @(posedge clk);
      #1 fire = 1'b1;
      @(posedge clk);
      #1 fire = 1'b0;
      chk("active_rise", int'(active), 1);
      repeat (2) @(posedge clk);
      #1 vsync = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("coincide_x", int'(x_pos), START_X);
      chk("coincide_y", int'(y_pos), START_Y);
    end else begin
      fire = 1'b1;
      @(posedge clk);
      #1 fire = 1'b0;
      chk("active_rise", int'(active), 1);
    end
    for (int k = 1; k <= n; k++) begin
      if (mid_fire != 0 && k == 3) begin
        power_x = 7'($urandom_range(0, 127));
        power_y = 7'($urandom_range(0, 127));
        fire = 1'b1;
        @(posedge clk);
        #1 fire = 1'b0;
      end
      frame();
      if (k < n) begin
        chk("step_x", int'(x_pos), traj_x[k-1]);
        chk("step_y", int'(y_pos), traj_y[k-1]);
        chk("still_flying", done_cnt, base);
      end
    end
    chk("flight_end", done_cnt, base + 1);
    chk("idle_active", int'(active), 0);
    chk("hit_held", int'(hit), r.hit);
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_r = exp_q.pop_front();
        chk("done_x", int'(x_pos), mon_r.x);
        chk("done_y", int'(y_pos), mon_r.y);
        chk("done_hit", int'(hit), mon_r.hit);
        chk("done_active", int'(active), 0);
        chk("done_width", int'(done_prev), 0);
      end
    end
    done_prev = done;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst = 1'b1;
    vsync = 1'b0;
    fire = 1'b0;
    power_x = '0;
    power_y = '0;
    wind = '0;
    target_x_lo = '0;
    target_x_hi = '0;
    target_top = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", int'(x_pos), START_X);
    chk("rst_y", int'(y_pos), START_Y);
    chk("rst_active", int'(active), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_hit", int'(hit), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Ground landing far from the target.
    run_flight(32, 64, 0, 1000, 1100, 0, 0, 0);
    // Target hit on the way down.
    run_flight(32, 64, 0, 150, 200, 40, 0, 0);
    // Strong headwind drives x negative.
    run_flight(0, 64, -16, 1000, 1100, 0, 0, 0);
    // Launch coinciding with a tick, and fire pulsed mid-flight.
    run_flight(32, 64, 0, 1000, 1100, 0, 1, 1);
    // Hit and ground on the same step: hit wins.
    run_flight(32, 64, 0, 180, 190, 0, 0, 0);

    // Reset mid-flight aborts with no done pulse.
    power_x = 7'd32;
    power_y = 7'd64;
    wind = 5'd0;
    target_x_lo = 12'd1000;
    target_x_hi = 12'd1100;
    target_top = 12'd0;
    base = done_cnt;
    fire = 1'b1;
    @(posedge clk);
    #1 fire = 1'b0;
    repeat (10) frame();
    chk("pre_rst_active", int'(active), 1);
    vsync = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_x", int'(x_pos), START_X);
    chk("abort_y", int'(y_pos), START_Y);
    chk("abort_active", int'(active), 0);
    vsync = 1'b0;
    repeat (3) frame();
    chk("abort_no_done", done_cnt, base);

    // Randomized flights.
    for (int i = 0; i < 15; i++) begin
      int lo;
      lo = int'($urandom_range(100, 600));
      run_flight(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 31)) - 16, lo, lo + int'($urandom_range(0, 80)),
                 int'($urandom_range(0, 120)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 1)));
    end

    repeat (10) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
